truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Sequencer that exhaustively drives a combinational N_IN-input, 1-output circuit
//  (e.g. Circuit_Behavioural) through all 2**N_IN input vectors in ascending order.
//  Waits SETTLE cycles per vector, samples the circuit output and builds the truth table.
//  Compares the result against a caller-supplied expected table and reports the
//  mismatch count and pass/fail.
//  Sits between a test/config master (start/abort handshake) and the circuit under control.
// PARAMETERS
//  N_IN    3   number of circuit inputs; table width is 2**N_IN (legal range 1..5)
//  SETTLE  2   idle cycles after each vector change before sampling (0 legal)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  start      in   1           request a sweep; accepted only in IDLE
//  abort      in   1           cancel a running sweep
//  expected   in   2**N_IN     expected truth table; bit k = output for vector k
//  dut_out    in   1           output of the controlled circuit
//  vec        out  N_IN        circuit inputs; vec[N_IN-1] -> in1 ... vec[0] -> in3 (N_IN=3)
//  busy       out  1           high while a sweep is in progress
//  done       out  1           one-cycle pulse when a sweep completes (not on abort)
//  table      out  2**N_IN     captured truth table
//  err_count  out  N_IN+1      number of mismatching bits vs expected
//  pass       out  1           1 when the last completed sweep had err_count==0
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; vec=0, busy=0, done=0, table=0, err_count=0, pass=0.
//  States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
//  IDLE:
//   - start=1 & abort=0 -> load exp_q<=expected, vec<=0, clear table/err_count/pass.
//   - Then go to SETTLE (cnt<=SETTLE-1), or straight to SAMPLE if SETTLE==0.
//   - start=1 & abort=1 -> ignored; stay in IDLE.
//  SETTLE: busy=1; vec held; cnt decrements; go to SAMPLE after SETTLE cycles.
//  SAMPLE: busy=1.
//   - table[vec]<=dut_out.
//   - if dut_out!=exp_q[vec], err_count<=err_count+1 (max 2**N_IN, no wrap).
//   - if vec==2**N_IN-1 -> DONE.
//   - else vec<=vec+1 -> SETTLE (or SAMPLE again if SETTLE==0).
//  DONE: busy=0, done=1 for exactly one cycle.
//   - pass<=(err_count==0); vec<=0.
//   - -> IDLE. start in DONE is ignored.
//  Timing: start sampled at edge 0; each vector holds SETTLE+1 cycles.
//   - done high during cycle 1 + 2**N_IN*(SETTLE+1) (25 for defaults).
//  abort while busy:
//   - next state IDLE, vec<=0, busy<=0, no done pulse, pass<=0.
//   - table/err_count keep their partial values.
//  start while busy is ignored. expected changes after acceptance have no effect.
//  table/err_count/pass hold their values until the next accepted start or reset.
// TESTING
//  1 start, expected=8'h96, dut=reference fn -> done at cycle 25, table=8'h96, err_count=0, pass=1
//  2 start, expected=8'h69, same dut -> table=8'h96, err_count=8, pass=0
//  3 dut_out stuck 0, expected=8'h96 -> table=8'h00, err_count=4, pass=0; vec sweeps 0..7, each held 3 cycles
//  4 abort at cycle 10 -> busy=0 next cycle, no done, pass=0; a new start then completes normally with done at cycle 25
//  5 start pulses while busy, and start+abort in IDLE -> no extra sweep, busy/done unaffected
//  6 rst asserted mid-sweep (cycle 14) -> all outputs 0 immediately (no clock edge); SETTLE=0 build: done at cycle 9

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Bus between the test/config master and the truth-table sweeper.
// The master side also drives dut_out_i, which carries the controlled circuit's output.
//
// Handshake: start_i is a level request. It is accepted on the first rising
// edge where the sweeper is idle and abort_i is low. busy_o acknowledges
// acceptance from the next cycle on. While busy_o is high, further start_i
// pulses are ignored. abort_i cancels the running sweep on the next edge.
// done_o pulses for one cycle only when a sweep runs to completion. The
// table_o, err_count_o and pass_o results are then stable until the next
// accepted start.
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    localparam int W = 1 << N_IN;

    logic            start_i;
    logic            abort_i;
    logic [W-1:0]    expected_i;
    logic            dut_out_i;
    logic [N_IN-1:0] vec_o;
    logic            busy_o;
    logic            done_o;
    logic [W-1:0]    table_o;
    logic [N_IN:0]   err_count_o;
    logic            pass_o;
    logic [1:0]      state_o;

    modport master (
        output start_i, abort_i, expected_i, dut_out_i,
        input  vec_o, busy_o, done_o, table_o, err_count_o, pass_o, state_o
    );

    modport slave (
        input  start_i, abort_i, expected_i, dut_out_i,
        output vec_o, busy_o, done_o, table_o, err_count_o, pass_o, state_o
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper. It drives every input vector 0 .. 2**N_IN-1
// in ascending order into a combinational circuit. Each vector is held for
// SETTLE+1 cycles, and the circuit output is sampled in the last of those cycles.
// The sampled bits build the captured table, which is compared bit by bit
// against an expected table latched when the sweep starts.
// N_IN must be in the range 1..5. SETTLE may be 0, in which case vectors
// change every cycle.
module truth_table_sweeper #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);
    localparam int W  = 1 << N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0]   CNT_INIT = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(W);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    exp_q;
    logic [N_IN-1:0] vec_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    table_q;
    logic [N_IN:0]   err_q;
    logic            pass_q;

    logic [W-1:0]    table_d;
    logic [N_IN:0]   err_d;
    logic            mismatch;
    logic            last_vec;

    // Results after a sample of the current vector: the table gets the new bit,
    // and a mismatch increments the error count, which saturates at 2**N_IN.
    always_comb begin
        mismatch         = (bus.dut_out_i != exp_q[vec_q]);
        last_vec         = (vec_q == VEC_LAST);
        table_d          = table_q;
        table_d[vec_q]   = bus.dut_out_i;
        err_d            = err_q;
        if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + (N_IN + 1)'(1);
        end
    end

    // Sequencer FSM. All outputs are registered here.
    // abort takes priority over the sample of the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i && !bus.abort_i) begin
                        exp_q   <= bus.expected_i;
                        vec_q   <= '0;
                        table_q <= '0;
                        err_q   <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_INIT;
                        state_q <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        vec_q   <= '0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_SAMPLE: begin
                    if (bus.abort_i) begin
                        state_q <= S_IDLE;
                        vec_q   <= '0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        table_q <= table_d;
                        err_q   <= err_d;
                        if (last_vec) begin
                            // The verdict uses the final count, so pass is valid together with done.
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                            vec_q   <= '0;
                        end else begin
                            vec_q   <= vec_q + N_IN'(1);
                            cnt_q   <= CNT_INIT;
                            state_q <= (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.vec_o       = vec_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.table_o     = table_q;
    assign bus.err_count_o = err_q;
    assign bus.pass_o      = pass_q;
    assign bus.state_o     = state_q;

    // The busy and done flags always agree with the state they represent.
    a_busy_matches_state: assert property (@(posedge clk) disable iff (rst)
        busy_q == ((state_q == S_SETTLE) || (state_q == S_SAMPLE)));
    a_done_matches_state: assert property (@(posedge clk) disable iff (rst)
        done_q == (state_q == S_DONE));
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper. Two instances share one clock: one uses
// SETTLE=2 (the default) and one uses SETTLE=0. Each sweep is predicted from
// the sweep rules directly. Vector k is sampled on edge (k+1)*(SETTLE+1) after
// acceptance. The table and error count follow from the circuit table, the
// expected table and the set of vectors sampled before any abort.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) ifa();
  truth_table_sweeper_if #(.N_IN(3)) ifb();

  truth_table_sweeper #(.N_IN(3), .SETTLE(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  truth_table_sweeper #(.N_IN(3), .SETTLE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  logic       sel = 1'b0;
  logic       start_r = 1'b0;
  logic       abort_r = 1'b0;
  logic [7:0] exp_r = 8'h00;
  logic [7:0] circ = 8'h96;

  assign ifa.start_i    = start_r & ~sel;
  assign ifa.abort_i    = abort_r & ~sel;
  assign ifa.expected_i = exp_r;
  assign ifa.dut_out_i  = circ[ifa.vec_o];
  assign ifb.start_i    = start_r & sel;
  assign ifb.abort_i    = abort_r & sel;
  assign ifb.expected_i = exp_r;
  assign ifb.dut_out_i  = circ[ifb.vec_o];

  logic       busy_m, done_m, pass_m;
  logic [2:0] vec_m;
  logic [7:0] tbl_m;
  logic [3:0] err_m;
  assign busy_m = sel ? ifb.busy_o : ifa.busy_o;
  assign done_m = sel ? ifb.done_o : ifa.done_o;
  assign pass_m = sel ? ifb.pass_o : ifa.pass_o;
  assign vec_m  = sel ? ifb.vec_o : ifa.vec_o;
  assign tbl_m  = sel ? ifb.table_o : ifa.table_o;
  assign err_m  = sel ? ifb.err_count_o : ifa.err_count_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] last_tbl_model = 8'h00;

  function automatic int popcnt8(input logic [7:0] x);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(x[i]);
    return n;
  endfunction

  // One full sweep on the selected instance. The task checks the busy, done
  // and vec timeline every cycle, and then checks the results it leaves behind.
  task automatic run_sweep(input bit s, input logic [7:0] e, input logic [7:0] f,
                           input int abort_at, input bit poke_start, input string name);
    int per = s ? 1 : 3;
    int total = 8 * per;
    int bad = 0;
    logic [7:0] mask = 8'h00;
    bit aborted = (abort_at != 0);
    logic [7:0] tbl_exp;
    int err_exp;
    bit pass_exp;
    @(negedge clk);
    sel = s; exp_r = e; circ = f; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    exp_r = 8'($urandom);
    for (int c = 1; c <= total + 3; c++) begin
      bit eb, ed;
      int ev;
      bit idle_now = (c > total + 1) || (aborted && c > abort_at);
      eb = !idle_now && (c <= total);
      ed = !idle_now && (c == total + 1);
      ev = eb ? (c - 1) / per : 0;
      if (busy_m !== eb || done_m !== ed || vec_m !== 3'(ev)) begin
        if (bad == 0)
          $display("FAIL timeline %s: cycle %0d got busy=%0b done=%0b vec=%0d, want busy=%0b done=%0b vec=%0d",
                   name, c, busy_m, done_m, vec_m, eb, ed, ev);
        bad++;
      end
      abort_r = aborted && (c == abort_at);
      start_r = poke_start && !aborted && (c == 5 || c == total - 1 || c == total + 1);
      @(negedge clk);
    end
    start_r = 1'b0;
    abort_r = 1'b0;
    tests_run++;
    if (bad != 0) tests_failed++;
    for (int v = 0; v < 8; v++)
      if (!aborted || (v + 1) * per < abort_at) mask[v] = 1'b1;
    tbl_exp = f & mask;
    err_exp = popcnt8((f ^ e) & mask);
    pass_exp = !aborted && (err_exp == 0);
    last_tbl_model = tbl_exp;
    tests_run++;
    if (tbl_m !== tbl_exp) begin
      tests_failed++;
      $display("FAIL table %s: got %h want %h", name, tbl_m, tbl_exp);
    end
    tests_run++;
    if (err_m !== 4'(err_exp)) begin
      tests_failed++;
      $display("FAIL err_count %s: got %0d want %0d", name, err_m, err_exp);
    end
    tests_run++;
    if (pass_m !== pass_exp) begin
      tests_failed++;
      $display("FAIL pass %s: got %0b want %0b", name, pass_m, pass_exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    tests_run++;
    if ({ifa.vec_o, ifa.busy_o, ifa.done_o, ifa.table_o, ifa.err_count_o, ifa.pass_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a: got vec=%0d busy=%0b done=%0b table=%h err=%0d pass=%0b want all zero",
               ifa.vec_o, ifa.busy_o, ifa.done_o, ifa.table_o, ifa.err_count_o, ifa.pass_o);
    end
    tests_run++;
    if ({ifb.vec_o, ifb.busy_o, ifb.done_o, ifb.table_o, ifb.err_count_o, ifb.pass_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_b: got vec=%0d busy=%0b done=%0b table=%h err=%0d pass=%0b want all zero",
               ifb.vec_o, ifb.busy_o, ifb.done_o, ifb.table_o, ifb.err_count_o, ifb.pass_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reference();
    run_sweep(1'b0, 8'h96, 8'h96, 0, 1'b0, "reference");
  endtask

  task automatic test_inverted_expected();
    run_sweep(1'b0, 8'h69, 8'h96, 0, 1'b0, "inverted_expected");
  endtask

  task automatic test_stuck_zero();
    run_sweep(1'b0, 8'h96, 8'h00, 0, 1'b0, "stuck_zero");
  endtask

  task automatic test_abort();
    run_sweep(1'b0, 8'h96, 8'hA5, 10, 1'b0, "abort_c10");
    run_sweep(1'b0, 8'h96, 8'h96, 0, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    bit bad = 1'b0;
    run_sweep(1'b0, 8'h3C, 8'h3C, 0, 1'b1, "start_while_busy");
    @(negedge clk);
    start_r = 1'b1; abort_r = 1'b1; exp_r = 8'hFF; circ = 8'h00;
    @(negedge clk);
    start_r = 1'b0; abort_r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy_m !== 1'b0 || done_m !== 1'b0 || tbl_m !== last_tbl_model) bad = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL start_abort_idle: got busy=%0b done=%0b table=%h want busy=0 done=0 table=%h",
               busy_m, done_m, tbl_m, last_tbl_model);
    end
  endtask

  task automatic test_settle_zero();
    run_sweep(1'b1, 8'h96, 8'h96, 0, 1'b0, "settle0_reference");
    run_sweep(1'b1, 8'h96, 8'hFF, 0, 1'b1, "settle0_mismatch");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    sel = 1'b0; exp_r = 8'h96; circ = 8'hFF; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int c = 1; c < 14; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({ifa.vec_o, ifa.busy_o, ifa.done_o, ifa.table_o, ifa.err_count_o, ifa.pass_o} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got vec=%0d busy=%0b done=%0b table=%h err=%0d pass=%0b want all zero",
               ifa.vec_o, ifa.busy_o, ifa.done_o, ifa.table_o, ifa.err_count_o, ifa.pass_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ifa.busy_o !== 1'b0 || ifa.table_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL after_reset_idle: got busy=%0b table=%h want busy=0 table=00", ifa.busy_o, ifa.table_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      bit s = 1'($urandom_range(0, 1));
      logic [7:0] f = 8'($urandom);
      logic [7:0] e = ($urandom_range(0, 2) == 0) ? f : 8'($urandom);
      int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, s ? 8 : 24)) : 0;
      bit pk = (ab == 0) && ($urandom_range(0, 1) == 1);
      run_sweep(s, e, f, ab, pk, $sformatf("random%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_reference();
    test_inverted_expected();
    test_stuck_zero();
    test_abort();
    test_back_to_back();
    test_settle_zero();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
